cic_interp_feeder: RTL and testbench
====================================

CIC_INTERP_FEEDER -- requirements
Module: cic_interp_feeder

Interface
REQ-001 Parameter ISZ, default 16: sample word width; matches the interpolator input width.
REQ-002 Parameter RATE, default 32: out_clk cycles per input sample (interpolation ratio); power of two, at least 4.
REQ-003 Parameter DEPTH, default 4: sample buffer depth; power of two, at least 2.
REQ-004 Parameter PRIME, default 2: buffer occupancy required to start strobing; 1 to DEPTH.
REQ-005 out_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on out_clk.
REQ-007 enable  input  1  run request; low forces IDLE.
REQ-008 s_data  input  ISZ  signed sample from the upstream source.
REQ-009 s_valid  input  1  s_data valid.
REQ-010 s_ready  output  1  buffer can accept; equals (count < DEPTH), combinational from registered count only.
REQ-011 in_clk  output  1  registered one-cycle sample strobe to the interpolator.
REQ-012 in  output  ISZ  registered signed sample, held between strobes.
REQ-013 underflow  output  1  registered one-cycle pulse, coincident with an in_clk that carries a zero-stuffed sample.
REQ-014 underflow_cnt  output  8  saturating count of underflow events.
REQ-015 running  output  1  high while the state is RUN.

Function
REQ-016 Buffer: DEPTH-entry FIFO with a count register (0..DEPTH); push when s_valid && s_ready.
REQ-017 States IDLE, PRIME, RUN; state, phase counter (log2 RATE bits) and outputs are all registered.
REQ-018 IDLE: phase=0, in_clk=0, in=0, FIFO flushed (count=0), s_ready=0 forced; transition to PRIME when enable=1.
REQ-019 PRIME: pushes accepted, phase=0, no strobes; transition to RUN on the edge where count >= PRIME is observed.
REQ-020 RUN: phase increments every cycle and wraps from RATE-1 to 0.
REQ-021 RUN, edge with phase==0: in_clk<=1; if count>0, in<=FIFO head and pop; otherwise in<=0, underflow<=1, and underflow_cnt increments.
REQ-022 RUN, edge with phase!=0: in_clk<=0 and underflow<=0; in holds its value.
REQ-023 Strobe period in RUN is exactly RATE cycles, including across underflows; RUN never returns to PRIME while enable=1.
REQ-024 First strobe: in_clk is high in the second cycle after the PRIME-to-RUN edge (one cycle later than that edge's following cycle).
REQ-025 Simultaneous push and pop: count is unchanged, and the popped word is the oldest entry.
REQ-026 Push when count==DEPTH is impossible because s_ready=0; a pop in the same cycle does not raise s_ready until the next cycle.
REQ-027 underflow_cnt saturates at 255; it is cleared only by reset, not by IDLE.
REQ-028 enable falling in any state: next state is IDLE; on that edge in_clk<=0, in<=0, underflow<=0, phase<=0, and the FIFO is flushed (a push in that cycle is discarded).
REQ-029 Data ordering: samples appear on in in exactly push order; no sample is duplicated or dropped while enable=1.

Reset
REQ-030 reset=1 at an edge: state=IDLE, phase=0, count=0, in_clk=0, in=0, underflow=0, underflow_cnt=0, running=0; reset takes priority over all other inputs.
REQ-031 Reset asserted mid-RUN aborts any pending strobe; no in_clk occurs in the cycle after the reset edge.
REQ-032 After reset is released, the block behaves as entering IDLE with enable sampled normally.

Verification
REQ-033 Prime/start: enable=1; push 0x0100, then 0x0200 on consecutive cycles -> RUN entered; in_clk pulses with in=0x0100, then 0x0200 exactly 32 cycles later; running=1.
REQ-034 Underflow: after REQ-033, no further pushes -> the third strobe carries in=0x0000 with underflow=1, underflow_cnt=1; strobe spacing stays 32.
REQ-035 Full/backpressure: while in PRIME with PRIME=4, push 4 words -> s_ready=0 at count=4; s_valid held high adds no entry; after the first pop, s_ready returns to 1 one cycle later.
REQ-036 Ordering stress: random s_valid at 50% duty, signed samples including 0x8000 and 0x7FFF -> the in sequence equals the pushed sequence plus zero-stuffed underflows; underflow_cnt matches the scoreboard count.
REQ-037 Enable drop mid-RUN with count=3 -> next cycle IDLE, in=0, count=0, s_ready=0; re-enable requires PRIME samples again before the next strobe.
REQ-038 Saturation/reset: force 300 underflows -> underflow_cnt=255; then assert reset mid-RUN -> all outputs zero on the next cycle and no in_clk pulse.

Source files
------------

// File: rtl/cic_interp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : cic_interp_feeder
// Purpose  : Buffers upstream samples in a small FIFO and presents them to a
//            CIC interpolator as one registered strobe every RATE cycles,
//            zero-stuffing (and counting) when the buffer runs dry.
// Revision : 1.0 - initial release
// ============================================================================
module cic_interp_feeder #(
  parameter int ISZ   = 16,
  parameter int RATE  = 32,
  parameter int DEPTH = 4,
  parameter int PRIME = 2
) (
  input  logic                  out_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic signed [ISZ-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  in_clk,
  output logic signed [ISZ-1:0] in,
  output logic                  underflow,
  output logic [7:0]            underflow_cnt,
  output logic                  running
);

  localparam int PW = $clog2(RATE);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  in_clk_q, in_clk_d;
  logic signed [ISZ-1:0] in_q, in_d;
  logic                  underflow_q, underflow_d;
  logic [7:0]            ucnt_q, ucnt_d;
  logic signed [ISZ-1:0] mem_q [DEPTH];
  logic                  push, pop;

  // Ready depends only on registered state so a pop never raises it combinationally.
  assign s_ready       = (state_q != ST_IDLE) && (count_q < CW'(DEPTH));
  assign in_clk        = in_clk_q;
  assign in            = in_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = ucnt_q;
  assign running       = (state_q == ST_RUN);

  // Next-state, FIFO bookkeeping and strobe generation.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    in_clk_d    = 1'b0;
    in_d        = in_q;
    underflow_d = 1'b0;
    ucnt_d      = ucnt_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (!enable) begin
      // Dropping enable flushes everything; a same-cycle push is discarded.
      state_d  = ST_IDLE;
      phase_d  = '0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      in_d     = '0;
    end else begin
      push = s_valid && s_ready;
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_PRIME;
          phase_d  = '0;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          in_d     = '0;
        end
        ST_PRIME: begin
          phase_d = '0;
          if (count_q >= CW'(PRIME)) state_d = ST_RUN;
        end
        ST_RUN: begin
          phase_d = phase_q + PW'(1);
          if (phase_q == '0) begin
            in_clk_d = 1'b1;
            if (count_q != '0) begin
              pop  = 1'b1;
              in_d = mem_q[rd_ptr_q];
            end else begin
              in_d        = '0;
              underflow_d = 1'b1;
              if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // State and output registers; reset overrides all other inputs.
  always_ff @(posedge out_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_clk_q    <= 1'b0;
      in_q        <= '0;
      underflow_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_clk_q    <= in_clk_d;
      in_q        <= in_d;
      underflow_q <= underflow_d;
      ucnt_q      <= ucnt_d;
    end
  end

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge out_clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= s_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_interp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_interp_feeder
// Purpose  : Directed self-checking bench for cic_interp_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_interp_feeder;

  logic        out_clk = 1'b0;
  logic        reset   = 1'b1;
  // main instance (defaults)
  logic        enable  = 1'b0;
  logic [15:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, in_clk, underflow, running;
  logic [15:0] in;
  logic [7:0]  underflow_cnt;
  // second instance: PRIME=4, RATE=8
  logic        enable2  = 1'b0;
  logic [15:0] s_data2  = '0;
  logic        s_valid2 = 1'b0;
  logic        s_ready2, in_clk2, underflow2, running2;
  logic [15:0] in2;
  logic [7:0]  underflow_cnt2;

  int n_vec = 0;
  int n_err = 0;

  cic_interp_feeder u_dut (
    .out_clk(out_clk), .reset(reset), .enable(enable), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .in_clk(in_clk), .in(in),
    .underflow(underflow), .underflow_cnt(underflow_cnt), .running(running)
  );

  cic_interp_feeder #(.ISZ(16), .RATE(8), .DEPTH(4), .PRIME(4)) u_dut_p4 (
    .out_clk(out_clk), .reset(reset), .enable(enable2), .s_data(s_data2),
    .s_valid(s_valid2), .s_ready(s_ready2), .in_clk(in_clk2), .in(in2),
    .underflow(underflow2), .underflow_cnt(underflow_cnt2), .running(running2)
  );

  always #5 out_clk = ~out_clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge out_clk);
    #1;
  endtask

  task automatic wait_strobe(input bit sel, input int max_cyc, output int cyc, output bit found);
    cyc   = 0;
    found = 1'b0;
    while (cyc < max_cyc && !found) begin
      step();
      cyc++;
      if ((sel ? in_clk2 : in_clk) === 1'b1) found = 1'b1;
    end
  endtask

  logic [15:0] sb_q [$];
  logic [15:0] exp_d;
  logic [15:0] pick;
  bit          v, acc, found;
  int          cyc, last_strobe, ucnt_model;
  logic [15:0] tbl2 [5];

  initial begin
    // ---------------- reset state ----------------
    step(); step();
    chk_eq("rst_in_clk", in_clk, 0);
    chk_eq("rst_in", in, 0);
    chk_eq("rst_underflow", underflow, 0);
    chk_eq("rst_ucnt", underflow_cnt, 0);
    chk_eq("rst_running", running, 0);
    chk_eq("rst_s_ready", s_ready, 0);
    reset = 1'b0;

    // ---------------- backpressure, PRIME=4 instance ----------------
    enable2 = 1'b1;
    step();
    chk_eq("p4_ready_prime", s_ready2, 1);
    s_valid2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data2 = 16'(i * 16'h11);
      step();
    end
    chk_eq("p4_full_ready", s_ready2, 0);
    s_data2 = 16'h0055;
    step();                                   // count=4 observed -> RUN, push blocked
    chk_eq("p4_full_hold", s_ready2, 0);
    chk_eq("p4_running", running2, 1);
    chk_eq("p4_no_strobe_yet", in_clk2, 0);
    step();                                   // first strobe, pop
    chk_eq("p4_strobe1", in_clk2, 1);
    chk_eq("p4_in1", in2, 16'h0011);
    chk_eq("p4_ready_after_pop", s_ready2, 1);
    step();                                   // 0x55 accepted now
    s_valid2 = 1'b0;
    tbl2[0] = 16'h0022; tbl2[1] = 16'h0033; tbl2[2] = 16'h0044;
    tbl2[3] = 16'h0055; tbl2[4] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(1'b1, 20, cyc, found);
      chk_eq($sformatf("p4_found%0d", i), found, 1);
      chk_eq($sformatf("p4_in%0d", i + 2), in2, tbl2[i]);
      chk_eq($sformatf("p4_uf%0d", i + 2), underflow2, (i == 4) ? 1 : 0);
    end
    enable2 = 1'b0;

    // ---------------- prime / start ----------------
    enable = 1'b1;
    step();
    chk_eq("prime_ready", s_ready, 1);
    chk_eq("prime_running", running, 0);
    s_valid = 1'b1; s_data = 16'h0100;
    step();
    s_data = 16'h0200;
    step();
    s_valid = 1'b0;
    step();
    chk_eq("run_entered", running, 1);
    chk_eq("no_strobe_on_entry", in_clk, 0);
    step();
    chk_eq("strobe1", in_clk, 1);
    chk_eq("strobe1_in", in, 16'h0100);
    chk_eq("strobe1_uf", underflow, 0);
    step();
    chk_eq("strobe1_end", in_clk, 0);
    chk_eq("in_held", in, 16'h0100);
    wait_strobe(1'b0, 40, cyc, found);
    chk_eq("strobe2_spacing", cyc, 31);
    chk_eq("strobe2_in", in, 16'h0200);
    wait_strobe(1'b0, 40, cyc, found);
    chk_eq("strobe3_spacing", cyc, 32);
    chk_eq("strobe3_in", in, 16'h0000);
    chk_eq("strobe3_uf", underflow, 1);
    chk_eq("strobe3_ucnt", underflow_cnt, 1);
    ucnt_model = 1;

    // ---------------- enable drop with count=3 ----------------
    s_valid = 1'b1;
    s_data = 16'h0A0A; step();
    s_data = 16'h0B0B; step();
    s_data = 16'h0C0C; step();
    s_valid = 1'b0;
    enable  = 1'b0;
    step();
    chk_eq("drop_in", in, 0);
    chk_eq("drop_ready", s_ready, 0);
    chk_eq("drop_running", running, 0);
    chk_eq("drop_in_clk", in_clk, 0);
    chk_eq("drop_ucnt_kept", underflow_cnt, 1);
    enable = 1'b1;
    step();
    chk_eq("reen_ready", s_ready, 1);
    wait_strobe(1'b0, 40, cyc, found);
    chk_eq("reen_no_strobe", found, 0);
    s_valid = 1'b1;
    s_data = 16'h0D0D; step();
    s_data = 16'h0E0E; step();
    s_valid = 1'b0;
    wait_strobe(1'b0, 40, cyc, found);
    chk_eq("reen_found", found, 1);
    chk_eq("reen_in", in, 16'h0D0D);

    // ---------------- ordering stress ----------------
    enable = 1'b0; step();
    enable = 1'b1; step();
    sb_q.delete();
    last_strobe = -1;
    for (int c = 0; c < 640; c++) begin
      v = (c < 320) && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       pick = 16'h8000;
        1:       pick = 16'h7FFF;
        default: pick = 16'($urandom);
      endcase
      s_valid = v; s_data = pick;
      acc = v && s_ready;
      step();
      if (in_clk) begin
        if (last_strobe >= 0) chk_eq("stress_spacing", c - last_strobe, 32);
        last_strobe = c;
        if (sb_q.size() == 0) begin
          chk_eq("stress_uf_in", in, 0);
          chk_eq("stress_uf_flag", underflow, 1);
          if (ucnt_model < 255) ucnt_model++;
        end else begin
          exp_d = sb_q.pop_front();
          chk_eq("stress_in", in, exp_d);
          chk_eq("stress_uf_flag", underflow, 0);
        end
      end
      if (acc) sb_q.push_back(pick);
    end
    s_valid = 1'b0;
    chk_eq("stress_ucnt", underflow_cnt, ucnt_model);

    // ---------------- saturation ----------------
    for (int i = 0; i < 300; i++) begin
      wait_strobe(1'b0, 40, cyc, found);
      if (!found) begin
        chk_eq("sat_timeout", found, 1);
        break;
      end
      if (ucnt_model < 255) ucnt_model++;
    end
    chk_eq("sat_ucnt", underflow_cnt, 255);
    chk_eq("sat_model", ucnt_model, 255);

    // ---------------- reset mid-RUN on a strobe edge ----------------
    for (int i = 0; i < 31; i++) step();
    reset = 1'b1;
    step();
    chk_eq("rrun_in_clk", in_clk, 0);
    chk_eq("rrun_in", in, 0);
    chk_eq("rrun_uf", underflow, 0);
    chk_eq("rrun_ucnt", underflow_cnt, 0);
    chk_eq("rrun_running", running, 0);
    chk_eq("rrun_ready", s_ready, 0);
    step();
    chk_eq("rrun_in_clk2", in_clk, 0);
    reset = 1'b0;
    step();
    chk_eq("post_rst_prime", s_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
